// File: rtl/pipa_pulse_sync_pkg.sv
// ============================================================================
// Module      : pipa_pulse_sync_pkg
// Description : Shared axis enumeration and pending-count sizing for the
//               PIPA pulse synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipa_pulse_sync_pkg;

    typedef enum logic [1:0] {
        AXIS_X = 2'd0,
        AXIS_Y = 2'd1,
        AXIS_Z = 2'd2
    } axis_e;

    localparam int NUM_AXES     = 3;
    localparam int CNT_W        = 4;
    localparam int SAT_DEFAULT  = 3;
    localparam int SYNC_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/pipa_pulse_sync_axis.sv
// ============================================================================
// Module      : pipa_axis
// Description : One PIPA axis: input synchronizers, saturating signed pending
//               count, request decode and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipa_axis
    import pipa_pulse_sync_pkg::*;
#(
    parameter int SAT         = SAT_DEFAULT,
    parameter int SYNC_STAGES = SYNC_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sam_i,
    input  logic pos_n_i,
    input  logic neg_n_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic req_p_o,
    output logic req_m_o,
    output logic both_o,
    output logic ovf_o
);

    localparam logic signed [CNT_W:0] SAT_P = (CNT_W+1)'(SAT);
    localparam logic signed [CNT_W:0] SAT_N = -SAT_P;
    localparam logic signed [CNT_W:0] ONE   = (CNT_W+1)'(1);

    logic [SYNC_STAGES-1:0]    pos_sync_q;
    logic [SYNC_STAGES-1:0]    neg_sync_q;
    logic signed [CNT_W-1:0]   count_q;
    logic signed [CNT_W-1:0]   count_d;
    logic                      ovf_q;
    logic                      ovf_d;
    logic signed [CNT_W:0]     sum_w;
    logic                      pos_w;
    logic                      neg_w;
    logic                      ovf_set_w;

    // Raw active-low levels are synchronized first and inverted only at the tap.
    assign pos_w = ~pos_sync_q[SYNC_STAGES-1];
    assign neg_w = ~neg_sync_q[SYNC_STAGES-1];

    assign req_p_o = ~count_q[CNT_W-1] & (|count_q);
    assign req_m_o = count_q[CNT_W-1];
    assign both_o  = sam_i & pos_w & neg_w;
    assign ovf_o   = ovf_q;

    always_comb begin
        sum_w     = {count_q[CNT_W-1], count_q};
        ovf_set_w = 1'b0;
        if (sam_i && pos_w && !neg_w) sum_w = sum_w + ONE;
        if (sam_i && neg_w && !pos_w) sum_w = sum_w - ONE;
        if (ack_i && req_p_o)         sum_w = sum_w - ONE;
        if (ack_i && req_m_o)         sum_w = sum_w + ONE;
        count_d = sum_w[CNT_W-1:0];
        if (sum_w > SAT_P) begin
            count_d   = SAT_P[CNT_W-1:0];
            ovf_set_w = 1'b1;
        end else if (sum_w < SAT_N) begin
            count_d   = SAT_N[CNT_W-1:0];
            ovf_set_w = 1'b1;
        end
        ovf_d = ovf_set_w | (ovf_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_sync_q <= '0;
            neg_sync_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            pos_sync_q <= {pos_sync_q[SYNC_STAGES-2:0], pos_n_i};
            neg_sync_q <= {neg_sync_q[SYNC_STAGES-2:0], neg_n_i};
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipa_pulse_sync.sv
// ============================================================================
// Module      : pipa_pulse_sync
// Description : Three-axis PIPA pulse synchronizer feeding counter-increment
//               requests, with sticky both-active and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipa_pulse_sync
    import pipa_pulse_sync_pkg::*;
#(
    parameter int SAT         = SAT_DEFAULT,
    parameter int SYNC_STAGES = SYNC_DEFAULT
) (
    input  logic                CLOCK,
    input  logic                rst,
    input  logic                PIPSAM,
    input  logic                PIPAXp_,
    input  logic                PIPAXm_,
    input  logic                PIPAYp_,
    input  logic                PIPAYm_,
    input  logic                PIPAZp_,
    input  logic                PIPAZm_,
    input  logic [NUM_AXES-1:0] CTRACK,
    input  logic                CLRPIP,
    output logic                PIPGXp,
    output logic                PIPGXm,
    output logic                PIPGYp,
    output logic                PIPGYm,
    output logic                PIPGZp,
    output logic                PIPGZm,
    output logic                PIPAFL,
    output logic [NUM_AXES-1:0] PIPOVF
);

    logic [NUM_AXES-1:0] pos_n_w;
    logic [NUM_AXES-1:0] neg_n_w;
    logic [NUM_AXES-1:0] req_p_w;
    logic [NUM_AXES-1:0] req_m_w;
    logic [NUM_AXES-1:0] both_w;
    logic                afl_q;
    logic                afl_d;

    assign pos_n_w[AXIS_X] = PIPAXp_;
    assign pos_n_w[AXIS_Y] = PIPAYp_;
    assign pos_n_w[AXIS_Z] = PIPAZp_;
    assign neg_n_w[AXIS_X] = PIPAXm_;
    assign neg_n_w[AXIS_Y] = PIPAYm_;
    assign neg_n_w[AXIS_Z] = PIPAZm_;

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        pipa_axis #(
            .SAT         (SAT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_axis (
            .clk_i   (CLOCK),
            .rst_i   (rst),
            .sam_i   (PIPSAM),
            .pos_n_i (pos_n_w[i]),
            .neg_n_i (neg_n_w[i]),
            .ack_i   (CTRACK[i]),
            .clr_i   (CLRPIP),
            .req_p_o (req_p_w[i]),
            .req_m_o (req_m_w[i]),
            .both_o  (both_w[i]),
            .ovf_o   (PIPOVF[i])
        );
    end

    assign PIPGXp = req_p_w[AXIS_X];
    assign PIPGXm = req_m_w[AXIS_X];
    assign PIPGYp = req_p_w[AXIS_Y];
    assign PIPGYm = req_m_w[AXIS_Y];
    assign PIPGZp = req_p_w[AXIS_Z];
    assign PIPGZm = req_m_w[AXIS_Z];
    assign PIPAFL = afl_q;

    // A fresh both-active event wins over a simultaneous clear.
    assign afl_d = (|both_w) | (afl_q & ~CLRPIP);

    always_ff @(posedge CLOCK) begin
        if (rst) afl_q <= 1'b0;
        else     afl_q <= afl_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_pipa_pulse_sync.sv
// ============================================================================
// Module      : tb_pipa_pulse_sync
// Description : Directed scoreboard bench for pipa_pulse_sync (SAT=3, 2 stages).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipa_pulse_sync;

    logic       CLOCK = 1'b0;
    logic       rst;
    logic       PIPSAM;
    logic       PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_;
    logic [2:0] CTRACK;
    logic       CLRPIP;
    logic       PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm;
    logic       PIPAFL;
    logic [2:0] PIPOVF;

    localparam logic [9:0] X_P   = 10'b10_0000_0000;
    localparam logic [9:0] Y_M   = 10'b00_0100_0000;
    localparam logic [9:0] Z_P   = 10'b00_0010_0000;
    localparam logic [9:0] Z_M   = 10'b00_0001_0000;
    localparam logic [9:0] AFL   = 10'b00_0000_1000;
    localparam logic [9:0] OVF_X = 10'b00_0000_0001;
    localparam logic [9:0] OVF_Y = 10'b00_0000_0010;
    localparam logic [9:0] OVF_Z = 10'b00_0000_0100;
    localparam logic [9:0] NONE  = 10'b00_0000_0000;

    int         n_pass  = 0;
    int         n_total = 0;
    string      tag_q[$];
    logic [9:0] exp_q[$];

    pipa_pulse_sync #(.SAT(3), .SYNC_STAGES(2)) dut (
        .CLOCK   (CLOCK),
        .rst     (rst),
        .PIPSAM  (PIPSAM),
        .PIPAXp_ (PIPAXp_),
        .PIPAXm_ (PIPAXm_),
        .PIPAYp_ (PIPAYp_),
        .PIPAYm_ (PIPAYm_),
        .PIPAZp_ (PIPAZp_),
        .PIPAZm_ (PIPAZm_),
        .CTRACK  (CTRACK),
        .CLRPIP  (CLRPIP),
        .PIPGXp  (PIPGXp),
        .PIPGXm  (PIPGXm),
        .PIPGYp  (PIPGYp),
        .PIPGYm  (PIPGYm),
        .PIPGZp  (PIPGZp),
        .PIPGZm  (PIPGZm),
        .PIPAFL  (PIPAFL),
        .PIPOVF  (PIPOVF)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic compare_one();
        string      tag;
        logic [9:0] exp_v;
        logic [9:0] obs;
        obs = {PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm, PIPAFL, PIPOVF};
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%b required=<entry>", obs);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s observed=%b required=%b", tag, obs, exp_v);
        end
    endtask

    // Push the expectation for the edge about to happen, then check after it.
    task automatic step(input string tag, input logic [9:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge CLOCK);
        #1;
        compare_one();
    endtask

    initial begin
        rst = 1'b1; PIPSAM = 1'b0; CTRACK = 3'b000; CLRPIP = 1'b0;
        PIPAXp_ = 1'b1; PIPAXm_ = 1'b1; PIPAYp_ = 1'b1;
        PIPAYm_ = 1'b1; PIPAZp_ = 1'b1; PIPAZm_ = 1'b1;
        step("reset", NONE);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("idle", NONE);

        // Sync latency, single + sample, hold without PIPSAM
        PIPAXp_ = 1'b0;
        step("lat_pre", NONE);
        PIPSAM = 1'b1;
        step("lat_early", NONE);
        step("x_first", X_P);
        PIPSAM = 1'b0;
        step("x_hold1", X_P);
        step("x_hold2", X_P);

        // Sample and ack in the same cycle cancel
        PIPSAM = 1'b1; CTRACK = 3'b001;
        step("x_sum", X_P);
        CTRACK = 3'b000;
        step("x_plus2", X_P);
        PIPSAM = 1'b0; PIPAXp_ = 1'b1;
        step("x_idle", X_P);

        // Acks drain +2 to zero; a further ack is ignored
        CTRACK = 3'b001;
        step("x_ack1", X_P);
        step("x_ack2", NONE);
        step("x_ack3", NONE);
        CTRACK = 3'b000;

        // Y saturates at -3, overflow flag, clear and set-over-clear priority
        PIPAYm_ = 1'b0;
        step("y_sync1", NONE);
        step("y_sync2", NONE);
        PIPSAM = 1'b1;
        step("y_s1", Y_M);
        step("y_s2", Y_M);
        step("y_s3", Y_M);
        step("y_s4_ovf", Y_M | OVF_Y);
        PIPSAM = 1'b0; CLRPIP = 1'b1;
        step("ovf_clr", Y_M);
        PIPSAM = 1'b1;
        step("ovf_prio", Y_M | OVF_Y);
        PIPSAM = 1'b0; CLRPIP = 1'b0;
        step("ovf_keep", Y_M | OVF_Y);
        CLRPIP = 1'b1;
        step("ovf_clr2", Y_M);
        CLRPIP = 1'b0; PIPAYm_ = 1'b1; CTRACK = 3'b010;
        step("y_ack1", Y_M);
        step("y_ack2", Y_M);
        step("y_ack3", NONE);
        CTRACK = 3'b000;

        // Z both active: no count change, sticky PIPAFL until CLRPIP
        PIPAZp_ = 1'b0; PIPAZm_ = 1'b0;
        step("z_sync1", NONE);
        step("z_sync2", NONE);
        PIPSAM = 1'b1;
        step("z_both", AFL);
        PIPSAM = 1'b0;
        step("afl_hold", AFL);
        PIPAZm_ = 1'b1;
        step("afl_hold2", AFL);
        step("afl_hold3", AFL);
        PIPSAM = 1'b1;
        step("z_plus", Z_P | AFL);
        PIPSAM = 1'b0; CLRPIP = 1'b1;
        step("afl_clr", Z_P);
        CLRPIP = 1'b0;

        // Load every axis and flag, then reset
        PIPAXp_ = 1'b0; PIPAYm_ = 1'b0;
        step("all_sync1", Z_P);
        step("all_sync2", Z_P);
        PIPSAM = 1'b1;
        step("all_s1", X_P | Y_M | Z_P);
        step("all_s2", X_P | Y_M | Z_P);
        step("all_s3", X_P | Y_M | Z_P | OVF_Z);
        step("all_s4", X_P | Y_M | Z_P | OVF_X | OVF_Y | OVF_Z);
        PIPSAM = 1'b0; PIPAXm_ = 1'b0;
        step("xm_sync1", X_P | Y_M | Z_P | OVF_X | OVF_Y | OVF_Z);
        step("xm_sync2", X_P | Y_M | Z_P | OVF_X | OVF_Y | OVF_Z);
        PIPSAM = 1'b1;
        step("x_both", X_P | Y_M | Z_P | AFL | OVF_X | OVF_Y | OVF_Z);
        rst = 1'b1; CTRACK = 3'b111; CLRPIP = 1'b1;
        step("rst_all", NONE);
        rst = 1'b0; PIPSAM = 1'b0; CTRACK = 3'b000; CLRPIP = 1'b0;
        PIPAXp_ = 1'b1; PIPAXm_ = 1'b1; PIPAYm_ = 1'b1; PIPAZp_ = 1'b1;
        for (int i = 0; i < 3; i++) step("post_idle", NONE);

        // Normal operation after reset
        PIPAZm_ = 1'b0;
        step("pr_sync1", NONE);
        step("pr_sync2", NONE);
        PIPSAM = 1'b1;
        step("post_rst", Z_M);
        PIPSAM = 1'b0;
        step("post_hold", Z_M);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/pipa_pulse_sync.md
PIPA_PULSE_SYNC -- requirements
Module: pipa_pulse_sync

Interface
REQ-001 Parameter SAT, default 3, meaning: per-axis pending-count magnitude limit, range 1..7.
REQ-002 Parameter SYNC_STAGES, default 2, meaning: synchronizer depth on the PIPA pulse inputs, range 2..3.
REQ-003 CLOCK  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 PIPSAM  input  1  sample strobe, high for one CLOCK cycle.
REQ-006 PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_  input  1 each  asynchronous PIPA pulses, active-low.
REQ-007 CTRACK  input  3  per-axis increment acknowledge from the counter priority chain: bit 0 X, bit 1 Y, bit 2 Z.
REQ-008 CLRPIP  input  1  clears the sticky fault flags.
REQ-009 PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm  output  1 each  counter-increment requests, active-high, consumed by the A9-class counter cells.
REQ-010 PIPAFL  output  1  sticky flag: both + and - seen at one sample.
REQ-011 PIPOVF  output  3  sticky per-axis flag: pending count saturated.

Function
REQ-012 Each PIPA input SHALL pass through SYNC_STAGES flops before use; inversion to active-high happens after the last stage.
REQ-013 The block SHALL keep one signed pending count per axis, width 4, range -SAT..+SAT.
REQ-014 On a cycle with PIPSAM=1, the synced + input of an axis SHALL add +1 to that axis's count, and the synced - input SHALL add -1; the result takes effect at the next edge.
REQ-015 If + and - are both active at one sample, the count SHALL NOT change and PIPAFL SHALL set at the next edge.
REQ-016 Outputs SHALL decode directly from the count registers: PIPGxp=1 iff count>0; PIPGxm=1 iff count<0; never both.
REQ-017 If CTRACK[i]=1 while axis i has a request active, the count SHALL move one step toward zero at the next edge.
REQ-018 A CTRACK[i] with no request active SHALL be ignored.
REQ-019 A sample and an ack on the same axis in the same cycle SHALL sum, e.g. count +2 with + sample and ack stays +2.
REQ-020 If a sample would push |count| beyond SAT, the count SHALL hold at ±SAT and PIPOVF[i] SHALL set.
REQ-021 Samples SHALL be ignored when PIPSAM=0, whatever the input levels.
REQ-022 Latency SHALL be SYNC_STAGES cycles from an input edge to a sample-visible level, plus 1 cycle from the PIPSAM edge to the request.
REQ-023 CLRPIP=1 SHALL clear PIPAFL and PIPOVF at the next edge; a set condition in the same cycle takes priority and leaves the flag at 1.
REQ-024 Axes SHALL be fully independent; there is no inter-axis priority inside this block.

Reset
REQ-025 rst=1 at an edge SHALL zero all counts, synchronizer flops, PIPAFL and PIPOVF; all outputs read 0 in the following cycle.
REQ-026 rst SHALL override PIPSAM, CTRACK and CLRPIP in the same cycle; outstanding requests are lost, not replayed.
REQ-027 Behaviour after rst deasserts SHALL equal that of a freshly powered block.

Structure
REQ-028 The axis enumeration (X=0, Y=1, Z=2), the count width, and the SAT default SHALL live in the shared agc package.
REQ-029 The per-axis logic (sync pair, count, decode, overflow flag) SHALL be one sub-module, pipa_axis, instantiated three times; PIPAFL is the OR of per-axis both-active events.

Verification
REQ-030 PIPAXp_ low, one PIPSAM pulse after sync, no ack -> PIPGXp=1 from the next cycle and held; PIPGXm=0.
REQ-031 PIPAYm_ low over 4 PIPSAM pulses with SAT=3, no ack -> count -3, PIPGYm=1, PIPOVF=3'b010; CLRPIP then clears PIPOVF while PIPGYm stays 1.
REQ-032 PIPAZp_ and PIPAZm_ both low at a PIPSAM pulse -> PIPGZp=PIPGZm=0, PIPAFL=1; PIPAFL stays 1 until CLRPIP.
REQ-033 X count +2, CTRACK[0] held high -> PIPGXp drops after exactly 2 acks; a third ack has no effect and the count stays 0.
REQ-034 X count +1, PIPSAM with + and CTRACK[0]=1 in the same cycle -> count stays +1 and PIPGXp stays 1.
REQ-035 rst asserted for 1 cycle with all counts nonzero and flags set -> all outputs 0 at the next cycle; a later sample behaves normally.
